// File: rtl/gamma_cycle_sched.sv
// rtl/gamma_cycle_sched.sv - gamma-cycle sequencer: binary-to-spike encode, first-edge decode
module gamma_cycle_sched #(
    parameter  int GAMMA_CYCLE_WIDTH = 16,
    parameter  int PULSE_WIDTH       = 8,
    parameter  int NUM_INPUTS        = 16,
    localparam int TW                = $clog2(GAMMA_CYCLE_WIDTH)
) (
    input  logic                     aclk,
    input  logic                     grst,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [NUM_INPUTS*TW-1:0] in_data,
    output logic                     gamma_start,
    output logic [TW-1:0]            tick,
    output logic [NUM_INPUTS-1:0]    spike_out,
    input  logic                     res_spike,
    output logic                     result_valid,
    input  logic                     result_ready,
    output logic [TW-1:0]            result,
    output logic                     no_spike
);

    localparam logic [TW-1:0] LAST_TICK = TW'(GAMMA_CYCLE_WIDTH - 1);
    // Pulse width held one bit wider than a tick so value+width never wraps.
    localparam logic [TW:0]   PW_EXT    = (TW+1)'(PULSE_WIDTH);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_REPORT
    } state_t;

    state_t                  r_state;
    logic [TW-1:0]           r_val [NUM_INPUTS];
    logic [TW-1:0]           r_tick;
    logic                    r_gamma_start;
    logic [NUM_INPUTS-1:0]   r_spike;
    logic                    r_res_q;
    logic                    r_found;
    logic [TW-1:0]           r_cap;
    logic                    r_result_valid;
    logic [TW-1:0]           r_result;
    logic                    r_no_spike;

    logic [TW-1:0]           w_tick_nxt;
    logic [NUM_INPUTS-1:0]   w_spike_nxt;
    logic                    w_edge;

    // True when tick t lies inside the pulse window starting at value v.
    function automatic logic in_window(input logic [TW-1:0] v, input logic [TW-1:0] t);
        logic [TW:0] v_ext;
        logic [TW:0] t_ext;
        v_ext = {1'b0, v};
        t_ext = {1'b0, t};
        return (t_ext >= v_ext) && (t_ext < v_ext + PW_EXT);
    endfunction

    assign in_ready     = (r_state == S_IDLE) && !grst;
    assign gamma_start  = r_gamma_start;
    assign tick         = r_tick;
    assign spike_out    = r_spike;
    assign result_valid = r_result_valid;
    assign result       = r_result;
    assign no_spike     = r_no_spike;
    assign w_edge       = res_spike && !r_res_q;

    // Spike pattern for the tick that will be presented next; in IDLE the values come straight from in_data.
    always_comb begin
        w_tick_nxt  = (r_state == S_RUN) ? r_tick + 1'b1 : '0;
        w_spike_nxt = '0;
        for (int i = 0; i < NUM_INPUTS; i++) begin
            w_spike_nxt[i] = in_window((r_state == S_IDLE) ? in_data[i*TW +: TW] : r_val[i],
                                       w_tick_nxt);
        end
    end

    // Cycle FSM: latch values, step ticks, capture first result edge, hold result until taken.
    always_ff @(posedge aclk or posedge grst) begin
        if (grst) begin
            r_state        <= S_IDLE;
            for (int i = 0; i < NUM_INPUTS; i++) r_val[i] <= '0;
            r_tick         <= '0;
            r_gamma_start  <= 1'b0;
            r_spike        <= '0;
            r_res_q        <= 1'b0;
            r_found        <= 1'b0;
            r_cap          <= '0;
            r_result_valid <= 1'b0;
            r_result       <= '0;
            r_no_spike     <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (in_valid) begin
                        for (int i = 0; i < NUM_INPUTS; i++) r_val[i] <= in_data[i*TW +: TW];
                        r_state       <= S_RUN;
                        r_tick        <= '0;
                        r_gamma_start <= 1'b1;
                        r_spike       <= w_spike_nxt;
                        r_res_q       <= 1'b0;
                        r_found       <= 1'b0;
                        r_cap         <= '0;
                    end
                end
                S_RUN: begin
                    r_gamma_start <= 1'b0;
                    r_res_q       <= res_spike;
                    if (w_edge && !r_found) begin
                        r_found <= 1'b1;
                        r_cap   <= r_tick;
                    end
                    if (r_tick == LAST_TICK) begin
                        // An edge first seen on the last tick also yields LAST_TICK.
                        r_state        <= S_REPORT;
                        r_tick         <= '0;
                        r_spike        <= '0;
                        r_result_valid <= 1'b1;
                        r_result       <= r_found ? r_cap : LAST_TICK;
                        r_no_spike     <= !r_found && !w_edge;
                    end else begin
                        r_tick  <= w_tick_nxt;
                        r_spike <= w_spike_nxt;
                    end
                end
                S_REPORT: begin
                    if (result_ready) begin
                        r_state        <= S_IDLE;
                        r_result_valid <= 1'b0;
                        r_result       <= '0;
                        r_no_spike     <= 1'b0;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_gamma_cycle_sched.sv
// tb/tb_gamma_cycle_sched.sv - self-checking bench for gamma_cycle_sched
module tb_gamma_cycle_sched;

    localparam int G  = 16;
    localparam int PW = 8;
    localparam int N  = 4;
    localparam int TW = 4;

    logic            aclk = 1'b0;
    logic            grst = 1'b1;
    logic            in_valid = 1'b0;
    logic            in_ready;
    logic [N*TW-1:0] in_data = '0;
    logic            gamma_start;
    logic [TW-1:0]   tick;
    logic [N-1:0]    spike_out;
    logic            res_spike = 1'b0;
    logic            result_valid;
    logic            result_ready = 1'b0;
    logic [TW-1:0]   result;
    logic            no_spike;

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct {
        logic [N*TW-1:0] data;
        logic [G-1:0]    res;
        int              hold;
        bit              pre;
        int              exp_r;
        int              exp_ns;
    } vec_t;

    gamma_cycle_sched #(
        .GAMMA_CYCLE_WIDTH(G),
        .PULSE_WIDTH(PW),
        .NUM_INPUTS(N)
    ) dut (
        .aclk(aclk),
        .grst(grst),
        .in_valid(in_valid),
        .in_ready(in_ready),
        .in_data(in_data),
        .gamma_start(gamma_start),
        .tick(tick),
        .spike_out(spike_out),
        .res_spike(res_spike),
        .result_valid(result_valid),
        .result_ready(result_ready),
        .result(result),
        .no_spike(no_spike)
    );

    always #5 aclk = ~aclk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference: line i is high on every tick t with v_i <= t < v_i + PW, t in 0..G-1.
    function automatic logic [N-1:0] model_spikes(input logic [N*TW-1:0] d, input int t);
        logic [N-1:0] r;
        r = '0;
        for (int i = 0; i < N; i++) begin
            int v;
            v = int'(d[i*TW +: TW]);
            r[i] = (t >= v) && (t < v + PW);
        end
        return r;
    endfunction

    // Reference: the first sampled-high tick is the first rising edge, since the line starts low.
    task automatic model_result(input logic [G-1:0] res, output int r, output int ns);
        r  = G - 1;
        ns = 1;
        for (int t = G - 1; t >= 0; t--) begin
            if (res[t]) begin
                r  = t;
                ns = 0;
            end
        end
    endtask

    task automatic wait_ready();
        int k;
        k = 0;
        while (!in_ready && k < 20) begin
            @(posedge aclk);
            #1;
            k++;
        end
        check("in_ready_idle", in_ready, 1);
    endtask

    task automatic run_case(input vec_t v);
        logic [TW-1:0] held;
        wait_ready();
        in_data   = v.data;
        in_valid  = 1'b1;
        res_spike = v.pre;
        @(posedge aclk);
        #1;
        in_valid = 1'b0;
        in_data  = N*TW'($urandom);
        for (int t = 0; t < G; t++) begin
            res_spike = v.res[t];
            check("tick", tick, t);
            check("gamma_start", gamma_start, (t == 0) ? 1 : 0);
            check("spike_out", spike_out, model_spikes(v.data, t));
            check("in_ready_run", in_ready, 0);
            check("result_valid_run", result_valid, 0);
            @(posedge aclk);
            #1;
        end
        res_spike = 1'($urandom);
        check("result_valid", result_valid, 1);
        check("result", result, v.exp_r);
        check("no_spike", no_spike, v.exp_ns);
        check("spike_report", spike_out, 0);
        check("tick_report", tick, 0);
        check("gamma_start_report", gamma_start, 0);
        held = result;
        for (int h = 0; h < v.hold; h++) begin
            in_valid  = 1'b1;
            in_data   = N*TW'($urandom);
            res_spike = 1'($urandom);
            @(posedge aclk);
            #1;
            check("hold_valid", result_valid, 1);
            check("hold_result", result, held);
            check("hold_no_spike", no_spike, v.exp_ns);
            check("hold_in_ready", in_ready, 0);
        end
        in_valid     = 1'b0;
        result_ready = 1'b1;
        @(posedge aclk);
        #1;
        result_ready = 1'b0;
        res_spike    = 1'b0;
        check("post_valid", result_valid, 0);
        check("post_result", result, 0);
        check("post_no_spike", no_spike, 0);
        check("post_in_ready", in_ready, 1);
    endtask

    initial begin
        vec_t vecs[6];
        vec_t rv;
        int   r;
        int   ns;

        vecs[0] = '{data: 16'h8F30, res: 16'hFE60, hold: 10, pre: 1'b0, exp_r: 5,  exp_ns: 0};
        vecs[1] = '{data: 16'h8F30, res: 16'h0000, hold: 0,  pre: 1'b0, exp_r: 15, exp_ns: 1};
        vecs[2] = '{data: 16'h1234, res: 16'hFFFF, hold: 2,  pre: 1'b1, exp_r: 0,  exp_ns: 0};
        vecs[3] = '{data: 16'h0F7A, res: 16'h8000, hold: 1,  pre: 1'b0, exp_r: 15, exp_ns: 0};
        vecs[4] = '{data: 16'hFFFF, res: 16'h0002, hold: 0,  pre: 1'b1, exp_r: 1,  exp_ns: 0};
        vecs[5] = '{data: 16'h9C41, res: 16'h0010, hold: 3,  pre: 1'b1, exp_r: 4,  exp_ns: 0};

        #1;
        check("rst_in_ready", in_ready, 0);
        check("rst_tick", tick, 0);
        check("rst_gamma_start", gamma_start, 0);
        check("rst_spike", spike_out, 0);
        check("rst_result_valid", result_valid, 0);
        check("rst_result", result, 0);
        check("rst_no_spike", no_spike, 0);
        @(posedge aclk);
        @(posedge aclk);
        #1;
        grst = 1'b0;
        #1;
        check("rel_in_ready", in_ready, 1);

        for (int i = 0; i < 6; i++) run_case(vecs[i]);

        // Reset at tick 7 of a running cycle.
        wait_ready();
        in_data  = 16'h8F30;
        in_valid = 1'b1;
        @(posedge aclk);
        #1;
        in_valid = 1'b0;
        for (int t = 0; t < 7; t++) begin
            res_spike = (t >= 3);
            @(posedge aclk);
            #1;
        end
        check("pre_rst_tick", tick, 7);
        check("pre_rst_spike", spike_out, model_spikes(16'h8F30, 7));
        grst = 1'b1;
        #1;
        check("mid_rst_tick", tick, 0);
        check("mid_rst_spike", spike_out, 0);
        check("mid_rst_gamma_start", gamma_start, 0);
        check("mid_rst_result_valid", result_valid, 0);
        check("mid_rst_result", result, 0);
        check("mid_rst_no_spike", no_spike, 0);
        check("mid_rst_in_ready", in_ready, 0);
        @(posedge aclk);
        #1;
        grst      = 1'b0;
        res_spike = 1'b0;
        @(posedge aclk);
        #1;
        check("after_rst_in_ready", in_ready, 1);
        check("after_rst_tick", tick, 0);
        check("after_rst_result_valid", result_valid, 0);
        run_case(vecs[0]);

        for (int k = 0; k < 24; k++) begin
            rv.data = N*TW'($urandom);
            rv.res  = G'($urandom) & G'($urandom);
            if ($urandom_range(0, 3) == 0) rv.res = '0;
            rv.hold = $urandom_range(0, 3);
            rv.pre  = 1'($urandom);
            model_result(rv.res, r, ns);
            rv.exp_r  = r;
            rv.exp_ns = ns;
            run_case(rv);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
